bp_cache_req_arbiter: RTL and testbench

Shares one cache-service engine (LCE request port, metadata port, completion strobe) between a core's I$ and D$ miss paths. It sits between the core's icache/dcache request outputs and a single downstream engine. It grants one miss at a time, forwards the owner's request and metadata, and holds ownership until completion. It publishes the owner so that fill packets can be steered.

---
 rtl/bp_common_pkg.sv | 23 ++
 rtl/bp_cache_req_arb_grant.sv | 46 ++++
 rtl/bp_cache_req_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_bp_cache_req_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_common_pkg
//  Purpose  : Shared types for the cache request arbiter slice. Holds the
//             arbiter state enum and owner encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package bp_common_pkg;

    // Arbiter FSM: idle (grant), metadata forwarding (one cycle), wait for
    // completion.
    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_meta = 2'd1,
        e_wait = 2'd2
    } bp_cache_req_arb_state_e;

    // Owner encoding published on owner_o.
    localparam logic c_owner_icache = 1'b0;
    localparam logic c_owner_dcache = 1'b1;

endpackage : bp_common_pkg
`default_nettype wire

// File: rtl/bp_cache_req_arb_grant.sv
`default_nettype none
// ============================================================================
//  Module   : bp_cache_req_arb_grant
//  Purpose  : One-hot grant between the I$ (bit 0) and D$ (bit 1) miss
//             requests.
//  Config   : BP_CACHE_REQ_ARB_RR_EN defined  -> round-robin grant using the
//                                                "last grant was D$" pointer.
//             BP_CACHE_REQ_ARB_RR_EN undefined -> fixed priority, D$ > I$.
//  Ports    : reqs_v           - request valids {D$, I$}
//             last_dcache      - (RR only) pointer, 1 = last grant went to D$
//             yumi             - (RR only) the granted request was accepted
//             next_last_dcache - (RR only) pointer value for the next cycle
//             grant            - one-hot grant {D$, I$}, zero when no request
//  Revision : 1.0 - initial release
// ============================================================================
module bp_cache_req_arb_grant (
    input  logic [1:0] reqs_v,
    output logic [1:0] grant
`ifdef BP_CACHE_REQ_ARB_RR_EN
    ,
    input  logic       last_dcache,
    input  logic       yumi,
    output logic       next_last_dcache
`endif
);

`ifdef BP_CACHE_REQ_ARB_RR_EN
    always_comb begin
        grant = reqs_v;
        // Contention: the side that did not win last time gets the grant.
        if (reqs_v == 2'b11) begin
            grant = last_dcache ? 2'b01 : 2'b10;
        end
        // Pointer only moves when a grant is actually consumed.
        next_last_dcache = yumi ? grant[1] : last_dcache;
    end
`else
    // D$ always wins; I$ may starve while D$ keeps missing.
    always_comb begin
        grant[1] = reqs_v[1];
        grant[0] = reqs_v[0] & ~reqs_v[1];
    end
`endif

endmodule : bp_cache_req_arb_grant
`default_nettype wire

// File: rtl/bp_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bp_cache_req_arbiter
//  Purpose  : Shares one cache-service engine between the I$ and D$ miss
//             paths. Grants one miss at a time, forwards the owner's request
//             (combinationally, in idle) and metadata (the cycle after
//             acceptance), routes the completion strobe to the owner and
//             publishes the owner for fill steering.
//  Config   : BP_CACHE_REQ_ARB_RR_EN - round-robin grant when defined,
//             fixed D$ > I$ priority otherwise.
//  Ports    : clk_i, reset_i (async, active-high)
//             icache_req_*/dcache_req_* - upstream request, metadata,
//                                         ready and completion per side
//             cache_req_*               - downstream engine request,
//                                         metadata, ready and completion
//             owner_o / owner_v_o       - current owner (0=I$, 1=D$), valid
//  Revision : 1.0 - initial release
// ============================================================================
module bp_cache_req_arbiter
    import bp_common_pkg::*;
#(
    parameter int req_width_p          = 32,
    parameter int req_metadata_width_p = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [req_width_p-1:0]          icache_req_i,
    input  logic                            icache_req_v_i,
    output logic                            icache_req_ready_o,
    input  logic [req_metadata_width_p-1:0] icache_req_metadata_i,
    input  logic                            icache_req_metadata_v_i,
    output logic                            icache_req_complete_o,

    input  logic [req_width_p-1:0]          dcache_req_i,
    input  logic                            dcache_req_v_i,
    output logic                            dcache_req_ready_o,
    input  logic [req_metadata_width_p-1:0] dcache_req_metadata_i,
    input  logic                            dcache_req_metadata_v_i,
    output logic                            dcache_req_complete_o,

    output logic [req_width_p-1:0]          cache_req_o,
    output logic                            cache_req_v_o,
    input  logic                            cache_req_ready_i,
    output logic [req_metadata_width_p-1:0] cache_req_metadata_o,
    output logic                            cache_req_metadata_v_o,
    input  logic                            cache_req_complete_i,

    output logic                            owner_o,
    output logic                            owner_v_o
);

    bp_cache_req_arb_state_e r_state;
    bp_cache_req_arb_state_e w_state_next;

    logic       r_owner;
    logic [1:0] w_reqs_v;
    logic [1:0] w_grant;
    logic       w_accept;
    logic       w_sel_dcache;

    assign w_reqs_v = {dcache_req_v_i, icache_req_v_i};

`ifdef BP_CACHE_REQ_ARB_RR_EN
    // 1 = last grant went to D$; resets so that I$ wins the first contention.
    logic r_last_dcache;
    logic w_next_last_dcache;

    bp_cache_req_arb_grant u_grant (
        .reqs_v           (w_reqs_v),
        .grant            (w_grant),
        .last_dcache      (r_last_dcache),
        .yumi             (w_accept),
        .next_last_dcache (w_next_last_dcache)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_last_dcache <= 1'b1;
        end else begin
            r_last_dcache <= w_next_last_dcache;
        end
    end
`else
    bp_cache_req_arb_grant u_grant (
        .reqs_v (w_reqs_v),
        .grant  (w_grant)
    );
`endif

    // ------------------------------------------------------------------
    // State and owner registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_owner <= c_owner_icache;
        end else if (w_accept) begin
            r_owner <= w_grant[1];
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next           = r_state;
        w_accept               = 1'b0;
        cache_req_v_o          = 1'b0;
        icache_req_ready_o     = 1'b0;
        dcache_req_ready_o     = 1'b0;
        cache_req_metadata_v_o = 1'b0;
        icache_req_complete_o  = 1'b0;
        dcache_req_complete_o  = 1'b0;

        case (r_state)
            e_idle: begin
                cache_req_v_o      = |w_reqs_v;
                icache_req_ready_o = w_grant[0] & cache_req_ready_i;
                dcache_req_ready_o = w_grant[1] & cache_req_ready_i;
                w_accept           = cache_req_v_o & cache_req_ready_i;
                if (w_accept) begin
                    w_state_next = e_meta;
                end
            end

            e_meta: begin
                cache_req_metadata_v_o = r_owner ? dcache_req_metadata_v_i
                                                 : icache_req_metadata_v_i;
                icache_req_complete_o  = ~r_owner & cache_req_complete_i;
                dcache_req_complete_o  =  r_owner & cache_req_complete_i;
                // A completion this early skips the wait state entirely.
                w_state_next = cache_req_complete_i ? e_idle : e_wait;
            end

            e_wait: begin
                icache_req_complete_o = ~r_owner & cache_req_complete_i;
                dcache_req_complete_o =  r_owner & cache_req_complete_i;
                if (cache_req_complete_i) begin
                    w_state_next = e_idle;
                end
            end

            default: begin
                w_state_next = e_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data muxes
    // ------------------------------------------------------------------
    // In idle the request follows the live grant; afterwards it follows the
    // latched owner so the engine sees a stable value.
    assign w_sel_dcache = (r_state == e_idle) ? w_grant[1] : r_owner;

    assign cache_req_o          = w_sel_dcache ? dcache_req_i : icache_req_i;
    assign cache_req_metadata_o = r_owner ? dcache_req_metadata_i
                                          : icache_req_metadata_i;

    assign owner_o   = r_owner;
    assign owner_v_o = (r_state != e_idle);

    // ------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------
    a_single_ready : assert property (@(posedge clk_i) disable iff (reset_i)
        !(icache_req_ready_o && dcache_req_ready_o));

    a_single_complete : assert property (@(posedge clk_i) disable iff (reset_i)
        !(icache_req_complete_o && dcache_req_complete_o));

    // A completion strobe while idle is dropped. The engine may legitimately
    // emit one after a mid-miss reset, so it is recorded rather than treated
    // as an error.
    c_dropped_complete : cover property (@(posedge clk_i) disable iff (reset_i)
        (r_state == e_idle) && cache_req_complete_i);

endmodule : bp_cache_req_arbiter
`default_nettype wire

// File: tb/tb_bp_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_cache_req_arbiter
//  Purpose  : Self-checking bench for bp_cache_req_arbiter. A transaction-
//             level model (busy flag, owner, first-cycle flag, last winner)
//             predicts every output each cycle; directed scenarios add
//             hand-computed literal checks.
//  Config   : BP_CACHE_REQ_ARB_RR_EN selects round-robin expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_cache_req_arbiter;

    localparam int RW = 16;
    localparam int MW = 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [RW-1:0] icache_req_i, dcache_req_i;
    logic          icache_req_v_i, dcache_req_v_i;
    logic          icache_req_ready_o, dcache_req_ready_o;
    logic [MW-1:0] icache_req_metadata_i, dcache_req_metadata_i;
    logic          icache_req_metadata_v_i, dcache_req_metadata_v_i;
    logic          icache_req_complete_o, dcache_req_complete_o;
    logic [RW-1:0] cache_req_o;
    logic          cache_req_v_o;
    logic          cache_req_ready_i;
    logic [MW-1:0] cache_req_metadata_o;
    logic          cache_req_metadata_v_o;
    logic          cache_req_complete_i;
    logic          owner_o, owner_v_o;

    int n_cmp = 0;
    int n_bad = 0;

    bp_cache_req_arbiter #(
        .req_width_p          (RW),
        .req_metadata_width_p (MW)
    ) dut (
        .clk_i                   (clk_i),
        .reset_i                 (reset_i),
        .icache_req_i            (icache_req_i),
        .icache_req_v_i          (icache_req_v_i),
        .icache_req_ready_o      (icache_req_ready_o),
        .icache_req_metadata_i   (icache_req_metadata_i),
        .icache_req_metadata_v_i (icache_req_metadata_v_i),
        .icache_req_complete_o   (icache_req_complete_o),
        .dcache_req_i            (dcache_req_i),
        .dcache_req_v_i          (dcache_req_v_i),
        .dcache_req_ready_o      (dcache_req_ready_o),
        .dcache_req_metadata_i   (dcache_req_metadata_i),
        .dcache_req_metadata_v_i (dcache_req_metadata_v_i),
        .dcache_req_complete_o   (dcache_req_complete_o),
        .cache_req_o             (cache_req_o),
        .cache_req_v_o           (cache_req_v_o),
        .cache_req_ready_i       (cache_req_ready_i),
        .cache_req_metadata_o    (cache_req_metadata_o),
        .cache_req_metadata_v_o  (cache_req_metadata_v_o),
        .cache_req_complete_i    (cache_req_complete_i),
        .owner_o                 (owner_o),
        .owner_v_o               (owner_v_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Model: one miss in flight at a time.
    // ------------------------------------------------------------------
    logic m_busy, m_owner, m_first, m_last_d;

    function automatic logic f_win(input logic iv, input logic dv,
                                   input logic last_d);
`ifdef BP_CACHE_REQ_ARB_RR_EN
        if (iv && dv) return !last_d;
        return dv;
`else
        if (last_d) begin end
        if (iv) begin end
        return dv;
`endif
    endfunction

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_busy   <= 1'b0;
            m_owner  <= 1'b0;
            m_first  <= 1'b0;
            m_last_d <= 1'b1;
        end else if (!m_busy) begin
            if ((icache_req_v_i || dcache_req_v_i) && cache_req_ready_i) begin
                m_busy   <= 1'b1;
                m_first  <= 1'b1;
                m_owner  <= f_win(icache_req_v_i, dcache_req_v_i, m_last_d);
                m_last_d <= f_win(icache_req_v_i, dcache_req_v_i, m_last_d);
            end
        end else begin
            m_first <= 1'b0;
            if (cache_req_complete_i) m_busy <= 1'b0;
        end
    end

    always @(negedge clk_i) begin : cmp
        logic w;
        if (!reset_i) begin
            w = f_win(icache_req_v_i, dcache_req_v_i, m_last_d);
            chk("cmp_owner", owner_o, m_owner);
            chk("cmp_owner_v", owner_v_o, m_busy);
            if (!m_busy) begin
                chk("cmp_req_v", cache_req_v_o, icache_req_v_i | dcache_req_v_i);
                if (icache_req_v_i || dcache_req_v_i)
                    chk("cmp_req", cache_req_o, w ? dcache_req_i : icache_req_i);
                chk("cmp_iready", icache_req_ready_o,
                    icache_req_v_i && !w && cache_req_ready_i);
                chk("cmp_dready", dcache_req_ready_o, w && cache_req_ready_i);
                chk("cmp_meta_v", cache_req_metadata_v_o, 0);
                chk("cmp_icomp", icache_req_complete_o, 0);
                chk("cmp_dcomp", dcache_req_complete_o, 0);
            end else begin
                chk("cmp_req_v", cache_req_v_o, 0);
                chk("cmp_iready", icache_req_ready_o, 0);
                chk("cmp_dready", dcache_req_ready_o, 0);
                chk("cmp_meta_v", cache_req_metadata_v_o,
                    m_first && (m_owner ? dcache_req_metadata_v_i
                                        : icache_req_metadata_v_i));
                if (m_first)
                    chk("cmp_meta", cache_req_metadata_o,
                        m_owner ? dcache_req_metadata_i : icache_req_metadata_i);
                chk("cmp_icomp", icache_req_complete_o, !m_owner && cache_req_complete_i);
                chk("cmp_dcomp", dcache_req_complete_o, m_owner && cache_req_complete_i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    logic [2:0] exp_seq;   // bit k = 1 when miss k goes to D$
    logic       got_d;
    logic       rr_en;

    initial begin
`ifdef BP_CACHE_REQ_ARB_RR_EN
        exp_seq = 3'b010;
        rr_en   = 1'b1;
`else
        exp_seq = 3'b111;
        rr_en   = 1'b0;
`endif
        reset_i = 1'b1;
        icache_req_i = '0; dcache_req_i = '0;
        icache_req_v_i = 0; dcache_req_v_i = 0;
        icache_req_metadata_i = '0; dcache_req_metadata_i = '0;
        icache_req_metadata_v_i = 0; dcache_req_metadata_v_i = 0;
        cache_req_ready_i = 0; cache_req_complete_i = 0;

        // Reset values
        @(negedge clk_i);
        chk("rst_owner_v", owner_v_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_req_v", cache_req_v_o, 0);
        chk("rst_iready", icache_req_ready_o, 0);
        chk("rst_dready", dcache_req_ready_o, 0);
        chk("rst_meta_v", cache_req_metadata_v_o, 0);
        chk("rst_comp", {icache_req_complete_o, dcache_req_complete_o}, 0);
        tick();
        reset_i = 1'b0;
        tick();

        // Single I$ miss, engine ready
        icache_req_i = 16'hA5A5; icache_req_metadata_i = 8'h3C;
        icache_req_metadata_v_i = 1; icache_req_v_i = 1; cache_req_ready_i = 1;
        @(negedge clk_i);
        chk("t1_iready_c0", icache_req_ready_o, 1);
        chk("t1_req_c0", cache_req_o, 16'hA5A5);
        tick();
        icache_req_v_i = 0;
        @(negedge clk_i);
        chk("t1_meta_v_c1", cache_req_metadata_v_o, 1);
        chk("t1_meta_c1", cache_req_metadata_o, 8'h3C);
        chk("t1_owner_v_c1", owner_v_o, 1);
        tick(); tick(); tick(); tick();
        cache_req_complete_i = 1;
        @(negedge clk_i);
        chk("t1_icomp_c5", icache_req_complete_o, 1);
        chk("t1_dcomp_c5", dcache_req_complete_o, 0);
        tick();
        cache_req_complete_i = 0;
        @(negedge clk_i);
        chk("t1_owner_v_c6", owner_v_o, 0);
        icache_req_metadata_v_i = 0;

        // Engine not ready for 3 cycles, then accept; complete in e_meta
        tick();
        dcache_req_i = 16'hBEEF; dcache_req_metadata_i = 8'h77;
        dcache_req_metadata_v_i = 1; dcache_req_v_i = 1; cache_req_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t2_dready_stall", dcache_req_ready_o, 0);
            chk("t2_owner_v_stall", owner_v_o, 0);
            tick();
        end
        cache_req_ready_i = 1;
        @(negedge clk_i);
        chk("t2_dready_c3", dcache_req_ready_o, 1);
        tick();
        dcache_req_v_i = 0; cache_req_complete_i = 1;
        @(negedge clk_i);
        chk("t2_dcomp_meta", dcache_req_complete_o, 1);
        chk("t2_meta", cache_req_metadata_o, 8'h77);
        chk("t2_owner", owner_o, 1);
        tick();
        cache_req_complete_i = 0;
        @(negedge clk_i);
        chk("t2_owner_v_after", owner_v_o, 0);
        dcache_req_metadata_v_i = 0;

        // Both requesters held valid for three misses
        tick();
        icache_req_i = 16'h1111; dcache_req_i = 16'h2222;
        icache_req_v_i = 1; dcache_req_v_i = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            got_d = dcache_req_ready_o;
            chk("t3_grant_d", got_d, exp_seq[k]);
            chk("t3_one_ready", icache_req_ready_o ^ dcache_req_ready_o, 1);
            if (!rr_en) chk("t3_iready_starved", icache_req_ready_o, 0);
            tick();
            tick();
            cache_req_complete_i = 1;
            @(negedge clk_i);
            chk("t3_owner_comp", exp_seq[k] ? dcache_req_complete_o
                                            : icache_req_complete_o, 1);
            chk("t3_other_comp", exp_seq[k] ? icache_req_complete_o
                                            : dcache_req_complete_o, 0);
            tick();
            cache_req_complete_i = 0;
        end
        icache_req_v_i = 0; dcache_req_v_i = 0;
        tick();

        // Reset during e_wait, then grant priority and stray completion
        icache_req_i = 16'h1234; icache_req_v_i = 1;
        @(negedge clk_i);
        chk("t4_iready", icache_req_ready_o, 1);
        tick();
        icache_req_v_i = 0;
        tick();
        @(negedge clk_i);
        chk("t4_owner_v_wait", owner_v_o, 1);
        #2 reset_i = 1;
        #1;
        chk("t4_owner_v_rst", owner_v_o, 0);
        chk("t4_owner_rst", owner_o, 0);
        tick();
        reset_i = 0;
        icache_req_v_i = 1; dcache_req_v_i = 1;
        @(negedge clk_i);
        chk("t4_iready_post", icache_req_ready_o, rr_en);
        chk("t4_dready_post", dcache_req_ready_o, !rr_en);
        tick();
        icache_req_v_i = 0; dcache_req_v_i = 0; cache_req_complete_i = 1;
        tick();
        cache_req_complete_i = 0;
        tick();
        cache_req_complete_i = 1;
        @(negedge clk_i);
        chk("t4_stray_icomp", icache_req_complete_o, 0);
        chk("t4_stray_dcomp", dcache_req_complete_o, 0);
        chk("t4_stray_owner_v", owner_v_o, 0);
        tick();
        cache_req_complete_i = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bp_cache_req_arbiter
`default_nettype wire
